dmem_router: RTL and testbench
==============================

Name: dmem_router

Overview:
- Parametrised data-memory front end. Successor of the fixed core/IO BRAM+DRAM data path.
- Arbitrates between two masters (core pipeline, IO loader) and routes each request by address: low region to on-chip BRAM, everything above to the external DRAM controller.
- Enforces one outstanding transaction with explicit valid/ready handshakes on the request, response and DRAM sides.
- Supports configurable BRAM size and read latency, and write acknowledgements.

Parameters:
- ADDR_W, 32, byte-address width of both masters.
- DATA_W, 32, data word width.
- BRAM_BYTES, 16384, size of the BRAM region; addresses below this go to BRAM. Must be a power of two.
- BRAM_LAT, 2, BRAM read latency in cycles; 1..4.
- DRAM_ADDR_W, 27, DRAM controller address width; dram_addr = addr[DRAM_ADDR_W:1].
- TIMEOUT_CYC, 1024, DRAM wait limit in cycles (optional feature only).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- core_active  in  1  1 selects the core master; 0 selects the IO master
- core_req_valid / core_req_ready  in / out  1 each  core request handshake
- core_req_we  in  1  core write (1) or read (0)
- core_req_addr  in  ADDR_W  core byte address
- core_req_wdata  in  DATA_W  core write data
- core_resp_valid / core_resp_ready  out / in  1 each  core response handshake
- core_resp_data  out  DATA_W  core read data
- core_resp_err  out  1  core error flag
- io_*  same set as core_*, IO master (io_req_valid ... io_resp_err)
- dram_valid  out  1  DRAM request strobe
- dram_rw  out  1  1 = DRAM write
- dram_addr  out  DRAM_ADDR_W  DRAM address
- dram_din  out  DATA_W  DRAM write data
- dram_ready  in  1  DRAM completion
- dram_dout  in  DATA_W  DRAM read data, valid with dram_ready

Behaviour:
- Reset: all *_req_ready, *_resp_valid, *_resp_err, dram_valid, dram_rw = 0; data and address outputs = 0; FSM = IDLE; latency counter = 0.
- Master selection:
  - Only the selected master sees req_ready = 1, and only in IDLE. The other master's req_ready = 0.
  - The owning master is latched at accept. A change of core_active mid-transaction does not redirect the response.
- Accept: on req_valid && req_ready, latch we, addr, wdata and owner.
- Address decode: addr < BRAM_BYTES selects BRAM, using word index addr[log2(BRAM_BYTES)-1:2]. addr[1:0] is ignored.
- FSM states:
  - IDLE: wait for an accepted request. BRAM write goes to RESP (BRAM write enable for exactly 1 cycle). BRAM read goes to BRAM_RD. DRAM access goes to DRAM_WAIT.
  - BRAM_RD: counter runs 1..BRAM_LAT; capture BRAM dout on the BRAM_LAT-th cycle, then go to RESP. BRAM read latency accept→resp_valid = BRAM_LAT+1 cycles.
  - DRAM_WAIT: dram_valid = 1 with addr/rw/din stable from the cycle after accept until dram_ready is sampled high. On that edge, capture dram_dout (reads; data = 0 for writes), drop dram_valid on the next cycle, go to RESP.
  - RESP: owner resp_valid = 1 with data/err held until resp_ready. On that edge go to IDLE; req_ready rises the following cycle.
- Write acknowledgement: writes also get a response, with data = 0 and err = 0.
- Simultaneous events:
  - dram_ready arriving when the owner already asserts resp_ready still passes through RESP (min 1 cycle); no combinational bypass.
  - dram_ready outside DRAM_WAIT is ignored.
- Reset mid-operation: FSM returns to IDLE next edge, dram_valid drops, and the pending response is discarded.
- Writes at the boundary: BRAM_BYTES-4 goes to BRAM; BRAM_BYTES goes to DRAM with dram_addr = BRAM_BYTES>>1.

Optional Feature:
- Macro: DMEM_ROUTER_TIMEOUT_EN.
- With the macro: a counter in DRAM_WAIT aborts after TIMEOUT_CYC cycles without dram_ready. On abort, dram_valid drops, then RESP with err = 1 and data = 32'hDEAD_BEEF; counter cleared on exit.
- Without the macro: DRAM_WAIT waits indefinitely; resp_err is tied to 0. Port list is identical in both builds.

Decomposition:
- Package dmem_pkg:
  - FSM state enum (IDLE, BRAM_RD, DRAM_WAIT, RESP)
  - owner enum (CORE, IO)
  - constant DEAD_DATA = 32'hDEAD_BEEF
  - function bram_hit(addr)
- One sub-module, dmem_bram: single-port inferred BRAM of depth BRAM_BYTES/4 with a BRAM_LAT-stage output pipeline. Replaces the vendor IP core.

Test Plan:
- core_active = 1; core writes 0x1234_5678 @0x100, then reads @0x100 → write resp at accept+1 with data 0; read resp_valid at accept+BRAM_LAT+1 with data 0x1234_5678.
- core read @0x4000, DRAM returns dram_ready after 7 cycles with 0xCAFE_0001 → dram_addr = 0x2000, dram_valid high 7 cycles; core_resp_data = 0xCAFE_0001.
- Hold core_resp_ready = 0 for 5 cycles → resp_valid and data stable throughout; req_ready stays 0 until 1 cycle after the handshake.
- core_active toggled to 0 during DRAM_WAIT → response still goes to core; io_req_ready = 1 only after return to IDLE.
- Assert rstn = 0 during DRAM_WAIT → next cycle dram_valid = 0 and FSM in IDLE; no resp_valid afterwards.
- With DMEM_ROUTER_TIMEOUT_EN and TIMEOUT_CYC = 16, dram_ready never asserted → resp_err = 1 and data 0xDEAD_BEEF after 16 wait cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory router (dmem_router) and its BRAM.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BRAM_RD, DRAM_WAIT, RESP} state_t;
  typedef enum logic {CORE, IO} owner_t;

  localparam logic [31:0] DEAD_DATA = 32'hDEAD_BEEF;

  // Everything below the BRAM size lives on-chip; the rest is external DRAM.
  function automatic logic bram_hit(input logic [63:0] addr, input logic [63:0] bytes);
    return addr < bytes;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port inferred BRAM with a LAT-stage registered read pipeline.
module dmem_bram #(
  parameter int AW     = 12,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**AW];
  logic [LAT-1:0][DATA_W-1:0] r_pipe;

  // Read-first: a write and a read of the same word return the old contents.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_pipe[0] <= r_mem[i_addr];
    for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end

  assign o_rdata = r_pipe[LAT-1];

endmodule

// File: rtl/dmem_router.sv
// Two-master data-memory front end: BRAM below BRAM_BYTES, DRAM above, one
// transaction in flight. Optional DRAM timeout via DMEM_ROUTER_TIMEOUT_EN.
module dmem_router
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BRAM_BYTES  = 16384,
  parameter int BRAM_LAT    = 2,
  parameter int DRAM_ADDR_W = 27,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   core_active,
  input  logic                   core_req_valid,
  output logic                   core_req_ready,
  input  logic                   core_req_we,
  input  logic [ADDR_W-1:0]      core_req_addr,
  input  logic [DATA_W-1:0]      core_req_wdata,
  output logic                   core_resp_valid,
  input  logic                   core_resp_ready,
  output logic [DATA_W-1:0]      core_resp_data,
  output logic                   core_resp_err,
  input  logic                   io_req_valid,
  output logic                   io_req_ready,
  input  logic                   io_req_we,
  input  logic [ADDR_W-1:0]      io_req_addr,
  input  logic [DATA_W-1:0]      io_req_wdata,
  output logic                   io_resp_valid,
  input  logic                   io_resp_ready,
  output logic [DATA_W-1:0]      io_resp_data,
  output logic                   io_resp_err,
  output logic                   dram_valid,
  output logic                   dram_rw,
  output logic [DRAM_ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0]      dram_din,
  input  logic                   dram_ready,
  input  logic [DATA_W-1:0]      dram_dout
);

  localparam int BRAM_AW = $clog2(BRAM_BYTES);
  localparam int CNT_W   = 3;

  state_t              r_state, w_state_nxt;
  owner_t              r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_idle, w_accept, w_sel_valid, w_sel_we, w_sel_hit;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata, w_bram_dout;
  logic [BRAM_AW-3:0]  w_bram_addr;
  logic                w_own_rdy, w_tmo, w_unused;

  assign w_idle      = (r_state == IDLE);
  assign w_sel_valid = core_active ? core_req_valid : io_req_valid;
  assign w_sel_we    = core_active ? core_req_we    : io_req_we;
  assign w_sel_addr  = core_active ? core_req_addr  : io_req_addr;
  assign w_sel_wdata = core_active ? core_req_wdata : io_req_wdata;
  assign w_sel_hit   = bram_hit(64'(w_sel_addr), 64'(BRAM_BYTES));

  assign core_req_ready = rstn & w_idle & core_active;
  assign io_req_ready   = rstn & w_idle & ~core_active;
  assign w_accept       = rstn & w_idle & w_sel_valid;

  assign w_own_rdy = (r_owner == CORE) ? core_resp_ready : io_resp_ready;

  // The read is issued on the accept edge so the pipeline output lines up with
  // the BRAM_LAT-th BRAM_RD cycle.
  assign w_bram_addr = w_idle ? w_sel_addr[BRAM_AW-1:2] : r_addr[BRAM_AW-1:2];

  dmem_bram #(.AW(BRAM_AW - 2), .DATA_W(DATA_W), .LAT(BRAM_LAT)) u_bram (
    .clk     (clk),
    .i_we    (w_accept & w_sel_we & w_sel_hit),
    .i_addr  (w_bram_addr),
    .i_wdata (w_sel_wdata),
    .o_rdata (w_bram_dout)
  );

`ifdef DMEM_ROUTER_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_err;
  assign w_tmo = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_state_nxt = w_sel_hit ? (w_sel_we ? RESP : BRAM_RD) : DRAM_WAIT;
      BRAM_RD:   if (r_cnt == CNT_W'(BRAM_LAT)) w_state_nxt = RESP;
      DRAM_WAIT: if (dram_ready || w_tmo) w_state_nxt = RESP;
      RESP:      if (w_own_rdy) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_owner <= CORE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
`ifdef DMEM_ROUTER_TIMEOUT_EN
      r_tcnt  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner <= core_active ? CORE : IO;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_rdata <= '0;
`ifdef DMEM_ROUTER_TIMEOUT_EN
        r_err   <= 1'b0;
`endif
        if (w_sel_hit && !w_sel_we) r_cnt <= CNT_W'(1);
      end
      case (r_state)
        BRAM_RD: begin
          if (r_cnt == CNT_W'(BRAM_LAT)) begin
            r_rdata <= w_bram_dout;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DRAM_WAIT: begin
          if (dram_ready) r_rdata <= r_we ? '0 : dram_dout;
`ifdef DMEM_ROUTER_TIMEOUT_EN
          if (dram_ready) begin
            r_tcnt <= '0;
          end else if (w_tmo) begin
            r_rdata <= DATA_W'(DEAD_DATA);
            r_err   <= 1'b1;
            r_tcnt  <= '0;
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign core_resp_valid = (r_state == RESP) & (r_owner == CORE);
  assign io_resp_valid   = (r_state == RESP) & (r_owner == IO);
  assign core_resp_data  = r_rdata;
  assign io_resp_data    = r_rdata;
`ifdef DMEM_ROUTER_TIMEOUT_EN
  assign core_resp_err   = core_resp_valid & r_err;
  assign io_resp_err     = io_resp_valid & r_err;
`else
  assign core_resp_err   = 1'b0;
  assign io_resp_err     = 1'b0;
`endif

  assign dram_valid = (r_state == DRAM_WAIT);
  assign dram_rw    = dram_valid & r_we;
  assign dram_addr  = r_addr[DRAM_ADDR_W:1];
  assign dram_din   = r_wdata;

  assign w_unused = &{1'b0, r_addr[0], r_addr[ADDR_W-1:DRAM_ADDR_W+1]};

endmodule

// File: tb/tb_dmem_router.sv
// Directed bench for dmem_router: BRAM/DRAM routing, latency, hold, owner latch, reset abort.
module tb_dmem_router;

  logic        clk = 1'b0;
  logic        rstn;
  logic        core_active;
  logic        core_req_valid, core_req_ready, core_req_we;
  logic [31:0] core_req_addr, core_req_wdata;
  logic        core_resp_valid, core_resp_ready, core_resp_err;
  logic [31:0] core_resp_data;
  logic        io_req_valid, io_req_ready, io_req_we;
  logic [31:0] io_req_addr, io_req_wdata;
  logic        io_resp_valid, io_resp_ready, io_resp_err;
  logic [31:0] io_resp_data;
  logic        dram_valid, dram_rw, dram_ready;
  logic [26:0] dram_addr;
  logic [31:0] dram_din, dram_dout;

  int n_chk = 0;
  int n_fail = 0;
  int nvld, nbad;

  always #5 clk = ~clk;

  dmem_router #(.ADDR_W(32), .DATA_W(32), .BRAM_BYTES(16384), .BRAM_LAT(2),
                .DRAM_ADDR_W(27), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn), .core_active(core_active),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_we(core_req_we), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_resp_valid(core_resp_valid),
    .core_resp_ready(core_resp_ready), .core_resp_data(core_resp_data),
    .core_resp_err(core_resp_err),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_we(io_req_we), .io_req_addr(io_req_addr),
    .io_req_wdata(io_req_wdata), .io_resp_valid(io_resp_valid),
    .io_resp_ready(io_resp_ready), .io_resp_data(io_resp_data),
    .io_resp_err(io_resp_err),
    .dram_valid(dram_valid), .dram_rw(dram_rw), .dram_addr(dram_addr),
    .dram_din(dram_din), .dram_ready(dram_ready), .dram_dout(dram_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; core_active = 1'b1;
    core_req_valid = 0; core_req_we = 0; core_req_addr = 0; core_req_wdata = 0; core_resp_ready = 0;
    io_req_valid = 0; io_req_we = 0; io_req_addr = 0; io_req_wdata = 0; io_resp_ready = 0;
    dram_ready = 0; dram_dout = 0;
    tick(); tick();
    chk1("rst_core_req_ready", core_req_ready, 1'b0);
    chk1("rst_io_req_ready", io_req_ready, 1'b0);
    chk1("rst_core_resp_valid", core_resp_valid, 1'b0);
    chk1("rst_io_resp_valid", io_resp_valid, 1'b0);
    chk1("rst_dram_valid", dram_valid, 1'b0);
    chk1("rst_dram_rw", dram_rw, 1'b0);
    chk32("rst_dram_addr", 32'(dram_addr), 32'h0);
    chk32("rst_resp_data", core_resp_data, 32'h0);
    rstn = 1'b1; #1;
    chk1("idle_core_req_ready", core_req_ready, 1'b1);
    chk1("idle_io_req_ready", io_req_ready, 1'b0);

    // BRAM write 0x100, ack one cycle after accept
    core_req_valid = 1; core_req_we = 1; core_req_addr = 32'h100; core_req_wdata = 32'h1234_5678;
    tick(); core_req_valid = 0; core_req_we = 0;
    chk1("bwr_resp_valid", core_resp_valid, 1'b1);
    chk32("bwr_resp_data", core_resp_data, 32'h0);
    chk1("bwr_resp_err", core_resp_err, 1'b0);
    chk1("bwr_req_ready_busy", core_req_ready, 1'b0);
    chk1("bwr_no_dram", dram_valid, 1'b0);
    core_resp_ready = 1;
    tick();
    chk1("bwr_done_valid", core_resp_valid, 1'b0);
    chk1("bwr_done_ready", core_req_ready, 1'b1);

    // BRAM read 0x100, resp_valid at accept+3
    core_req_valid = 1; core_req_addr = 32'h100;
    tick(); core_req_valid = 0;
    chk1("brd_lat1", core_resp_valid, 1'b0);
    tick();
    chk1("brd_lat2", core_resp_valid, 1'b0);
    tick();
    chk1("brd_lat3", core_resp_valid, 1'b1);
    chk32("brd_data", core_resp_data, 32'h1234_5678);
    tick();

    // Boundary: 0x3FFC stays in BRAM
    core_req_valid = 1; core_req_we = 1; core_req_addr = 32'h3FFC; core_req_wdata = 32'hBBBB_0001;
    tick(); core_req_valid = 0; core_req_we = 0;
    chk1("edge_bram_resp", core_resp_valid, 1'b1);
    chk1("edge_bram_no_dram", dram_valid, 1'b0);
    tick();
    core_req_valid = 1;
    tick(); core_req_valid = 0;
    tick(); tick();
    chk32("edge_bram_rdback", core_resp_data, 32'hBBBB_0001);
    tick();

    // Boundary: 0x4000 goes to DRAM; ready while resp_ready already high
    core_req_valid = 1; core_req_we = 1; core_req_addr = 32'h4000; core_req_wdata = 32'h5555_AAAA;
    tick(); core_req_valid = 0; core_req_we = 0;
    chk1("dwr_valid", dram_valid, 1'b1);
    chk1("dwr_rw", dram_rw, 1'b1);
    chk32("dwr_addr", 32'(dram_addr), 32'h2000);
    chk32("dwr_din", dram_din, 32'h5555_AAAA);
    chk1("dwr_no_resp_yet", core_resp_valid, 1'b0);
    dram_ready = 1; dram_dout = 32'hFFFF_FFFF;
    tick(); dram_ready = 0;
    chk1("dwr_dram_drop", dram_valid, 1'b0);
    chk1("dwr_resp_valid", core_resp_valid, 1'b1);
    chk32("dwr_resp_data", core_resp_data, 32'h0);
    tick();

    // Stray dram_ready in IDLE
    dram_ready = 1; dram_dout = 32'h0BAD_0BAD;
    tick(); dram_ready = 0;
    chk1("stray_no_resp", core_resp_valid, 1'b0);
    chk1("stray_idle_ready", core_req_ready, 1'b1);

    // DRAM read, ready on 7th wait cycle, response held 5 extra cycles
    core_resp_ready = 0;
    core_req_valid = 1; core_req_addr = 32'h4000;
    tick(); core_req_valid = 0;
    chk32("drd_addr", 32'(dram_addr), 32'h2000);
    chk1("drd_rw", dram_rw, 1'b0);
    nvld = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) begin dram_ready = 1; dram_dout = 32'hCAFE_0001; end
      if (dram_valid) nvld++;
      tick();
    end
    dram_ready = 0; dram_dout = 0;
    chk32("drd_valid_cycles", 32'(nvld), 32'd7);
    chk1("drd_dram_drop", dram_valid, 1'b0);
    chk1("drd_resp_valid", core_resp_valid, 1'b1);
    chk32("drd_resp_data", core_resp_data, 32'hCAFE_0001);
    nbad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (core_resp_valid !== 1'b1 || core_resp_data !== 32'hCAFE_0001 || core_req_ready !== 1'b0) nbad++;
    end
    chk32("hold_stable", 32'(nbad), 32'd0);
    core_resp_ready = 1; #1;
    chk1("hold_hs_ready_low", core_req_ready, 1'b0);
    tick();
    chk1("hold_done_valid", core_resp_valid, 1'b0);
    chk1("hold_done_ready", core_req_ready, 1'b1);

    // Owner latched: core_active flips during DRAM wait
    core_req_valid = 1; core_req_addr = 32'h4004;
    tick(); core_req_valid = 0;
    core_active = 0;
    io_req_valid = 1; io_req_we = 1; io_req_addr = 32'h200; io_req_wdata = 32'h0000_10AD; io_resp_ready = 1;
    #1;
    chk1("own_io_ready_busy", io_req_ready, 1'b0);
    chk1("own_core_ready_busy", core_req_ready, 1'b0);
    chk32("own_dram_addr", 32'(dram_addr), 32'h2002);
    tick();
    dram_ready = 1; dram_dout = 32'hA5A5_0002;
    tick(); dram_ready = 0;
    chk1("own_core_resp", core_resp_valid, 1'b1);
    chk1("own_io_no_resp", io_resp_valid, 1'b0);
    chk32("own_core_data", core_resp_data, 32'hA5A5_0002);
    chk1("own_io_ready_resp", io_req_ready, 1'b0);
    tick();
    chk1("own_io_ready_idle", io_req_ready, 1'b1);
    tick(); io_req_valid = 0; io_req_we = 0;
    chk1("io_wr_resp", io_resp_valid, 1'b1);
    chk1("io_wr_core_quiet", core_resp_valid, 1'b0);
    chk32("io_wr_data", io_resp_data, 32'h0);
    tick();
    chk1("io_wr_done", io_resp_valid, 1'b0);
    core_active = 1;
    core_req_valid = 1; core_req_addr = 32'h200;
    tick(); core_req_valid = 0;
    tick(); tick();
    chk32("io_wr_rdback", core_resp_data, 32'h0000_10AD);
    tick();

    // Reset during DRAM wait discards the transaction
    core_req_valid = 1; core_req_addr = 32'h8000;
    tick(); core_req_valid = 0;
    tick();
    chk1("rstmid_waiting", dram_valid, 1'b1);
    rstn = 0;
    tick();
    chk1("rstmid_dram_drop", dram_valid, 1'b0);
    chk1("rstmid_req_ready", core_req_ready, 1'b0);
    rstn = 1; dram_ready = 1; dram_dout = 32'h0000_0012;
    tick(); dram_ready = 0;
    chk1("rstmid_no_resp", core_resp_valid, 1'b0);
    chk1("rstmid_idle", core_req_ready, 1'b1);
    tick();
    chk1("rstmid_no_resp2", core_resp_valid, 1'b0);

`ifdef DMEM_ROUTER_TIMEOUT_EN
    core_req_valid = 1; core_req_addr = 32'hC000;
    tick(); core_req_valid = 0;
    for (int i = 0; i < 15; i++) tick();
    chk1("tmo_not_yet", core_resp_valid, 1'b0);
    chk1("tmo_still_wait", dram_valid, 1'b1);
    tick();
    chk1("tmo_resp", core_resp_valid, 1'b1);
    chk1("tmo_err", core_resp_err, 1'b1);
    chk32("tmo_data", core_resp_data, 32'hDEAD_BEEF);
    chk1("tmo_dram_drop", dram_valid, 1'b0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
